// File: rtl/seven_seg_display_arbiter.sv
// Four-digit seven-segment scan controller shared by two requesters.
// Ownership and displayed data change only at frame boundaries, so a frame never tears.
module seven_seg_display_arbiter #(
    parameter int unsigned SCAN_PERIOD = 100000,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int unsigned CNT_W  = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int unsigned HELD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [HELD_W:0]   HOLD_EXT = (HELD_W + 1)'(HOLD_FRAMES);
    localparam logic [HELD_W-1:0] HOLD_SAT = HELD_W'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    state_e            state_q, state_d;
    logic [HELD_W-1:0] held_q, held_d;
    logic              last_b_q, last_b_d;
    logic [15:0]       frame_buf_q, frame_buf_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic [3:0]        an_q, an_d;
    logic [3:0]        digit_q, digit_d;
    logic              frame_done_q, frame_done_d;

    logic              tick_c;
    logic [HELD_W:0]   hold_next_c;

    // State register; last_b_q=1 means requester B was the most recent owner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            state_q      <= IDLE;
            held_q       <= '0;
            last_b_q     <= 1'b1;
            frame_buf_q  <= 16'h0000;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            an_q         <= 4'b1111;
            digit_q      <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            held_q       <= held_d;
            last_b_q     <= last_b_d;
            frame_buf_q  <= frame_buf_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            an_q         <= an_d;
            digit_q      <= digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Scan cadence, frame-boundary arbitration and registered output decode.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        state_d      = state_q;
        held_d       = held_q;
        last_b_d     = last_b_q;
        frame_buf_d  = frame_buf_q;
        frame_done_d = 1'b0;
        tick_c       = (cnt_q == CNT_MAX);
        hold_next_c  = {1'b0, held_q} + (HELD_W + 1)'(1);

        if (tick_c) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        if (tick_c && (idx_q == 2'd3)) begin
            frame_done_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (req_a && (!req_b || last_b_q)) begin
                        state_d = OWN_A;
                    end else if (req_b) begin
                        state_d = OWN_B;
                    end
                end
                OWN_A: begin
                    if (!req_a) begin
                        state_d = req_b ? OWN_B : IDLE;
                    end else if (req_b && (hold_next_c >= HOLD_EXT)) begin
                        state_d = OWN_B;
                    end else begin
                        held_d = (hold_next_c > HOLD_EXT) ? HOLD_SAT : hold_next_c[HELD_W-1:0];
                    end
                end
                OWN_B: begin
                    if (!req_b) begin
                        state_d = req_a ? OWN_A : IDLE;
                    end else if (req_a && (hold_next_c >= HOLD_EXT)) begin
                        state_d = OWN_A;
                    end else begin
                        held_d = (hold_next_c > HOLD_EXT) ? HOLD_SAT : hold_next_c[HELD_W-1:0];
                    end
                end
                default: state_d = IDLE;
            endcase

            if (state_d != state_q) begin
                held_d = '0;
                if (state_d == OWN_A) begin
                    last_b_d = 1'b0;
                end else if (state_d == OWN_B) begin
                    last_b_d = 1'b1;
                end
            end

            case (state_d)
                OWN_A:   frame_buf_d = data_a;
                OWN_B:   frame_buf_d = data_b;
                default: frame_buf_d = 16'h0000;
            endcase
        end

        // Outputs are registered from next-state values so they align with the state they describe.
        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
        if (gnt_a_d || gnt_b_d) begin
            an_d    = ~(4'b0001 << idx_d);
            digit_d = frame_buf_d[{idx_d, 2'b00} +: 4];
        end else begin
            an_d    = 4'b1111;
            digit_d = 4'h0;
        end
    end

    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign an         = an_q;
    assign digit      = digit_q;
    assign frame_done = frame_done_q;

endmodule
